mmio_responder: RTL and testbench

- Memory-mapped I/O target for the CPU's 0x8000_00xx window.
- Serves the data-memory side of the pipeline: it decodes addresses, holds a one-byte UART RX buffer and a one-byte UART TX buffer, and maintains the cycle and retired-instruction counters.
- Faces the UART receiver/transmitter with ready/valid byte handshakes.
- Read data is registered, so it lines up with the memory/writeback stage.

---
 rtl/mmio_responder_if.sv | 25 ++
 rtl/mmio_responder.sv | 90 +++++++++
 tb/tb_mmio_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// CPU data-memory bus and UART byte handshakes for the MMIO responder.
interface mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  modport master (
    output addr, wdata, we, re, inst_retire, uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );

  modport slave (
    input  addr, wdata, we, re, inst_retire, uart_rx_data, uart_rx_valid, uart_tx_ready,
    output rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO target for the 0x8000_00xx window: UART RX/TX byte buffers plus
// cycle and retired-instruction counters, with registered read data.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input logic              clk,
  input logic              rst,
  mmio_responder_if.slave  bus
);

  logic             rx_full;
  logic [7:0]       rx_buf;
  logic             tx_full;
  logic [7:0]       tx_buf;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_next;

  logic sel_ctrl, sel_rx, sel_tx, sel_cyc, sel_ins, sel_rst;
  logic rx_accept, rx_pop, tx_done, tx_accept, cnt_clear;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  assign sel_ctrl = (bus.addr == BASE_ADDR + 32'h00);
  assign sel_rx   = (bus.addr == BASE_ADDR + 32'h04);
  assign sel_tx   = (bus.addr == BASE_ADDR + 32'h08);
  assign sel_cyc  = (bus.addr == BASE_ADDR + 32'h10);
  assign sel_ins  = (bus.addr == BASE_ADDR + 32'h14);
  assign sel_rst  = (bus.addr == BASE_ADDR + 32'h18);

  assign bus.uart_rx_ready = ~rx_full & ~rst;
  assign bus.uart_tx_valid = tx_full;
  assign bus.uart_tx_data  = tx_buf;
  assign bus.rdata         = rdata_q;

  // Ready is low while full, so accept and pop are mutually exclusive.
  assign rx_accept = bus.uart_rx_valid & bus.uart_rx_ready;
  assign rx_pop    = bus.re & sel_rx & rx_full;
  assign tx_done   = tx_full & bus.uart_tx_ready;
  assign tx_accept = bus.we & sel_tx & (~tx_full | bus.uart_tx_ready);
  assign cnt_clear = bus.we & sel_rst;

  always_comb begin
    rd_next = '0;
    if (sel_ctrl)     rd_next = {30'b0, rx_full, ~tx_full};
    else if (sel_rx)  rd_next = {24'b0, rx_buf};
    else if (sel_cyc) rd_next = 32'(cycle_cnt);
    else if (sel_ins) rd_next = 32'(instr_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      rx_full   <= 1'b0;
      rx_buf    <= '0;
      tx_full   <= 1'b0;
      tx_buf    <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (bus.re) rdata_q <= rd_next;

      if (rx_accept) begin
        rx_buf  <= bus.uart_rx_data;
        rx_full <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end

      if (tx_accept) begin
        tx_buf  <= bus.wdata[7:0];
        tx_full <= 1'b1;
      end else if (tx_done) begin
        tx_full <= 1'b0;
      end

      if (cnt_clear) begin
        cycle_cnt <= '0;
        instr_cnt <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        instr_cnt <= instr_cnt + CNT_W'(bus.inst_retire);
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_mmio_responder;

  localparam logic [31:0] A_CTRL = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_INS  = 32'h8000_0014;
  localparam logic [31:0] A_RST  = 32'h8000_0018;
  localparam logic [31:0] A_N0C  = 32'h8000_000C;
  localparam logic [31:0] A_N20  = 32'h8000_0020;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_responder_if bus ();

  mmio_responder #(.BASE_ADDR(32'h8000_0000), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        retire;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: one-deep byte queues for the UART buffers.
  logic [7:0]  m_rxq[$];
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rx_last = 8'h00;
  logic [31:0] m_cycle = 0;
  logic [31:0] m_instr = 0;
  logic [31:0] m_rdata = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    case (a)
      A_CTRL:  return {30'b0, m_rxq.size() != 0, m_txq.size() == 0};
      A_RX:    return {24'b0, m_rx_last};
      A_CYC:   return m_cycle;
      A_INS:   return m_instr;
      default: return 32'h0;
    endcase
  endfunction

  // Entered and left at a falling edge.
  task automatic step(input vec_t v);
    logic [31:0] exp_rd;
    logic        rx_empty, tx_empty, hs;
    rst               = v.rst;
    bus.addr          = v.addr;
    bus.wdata         = v.wdata;
    bus.we            = v.we;
    bus.re            = v.re;
    bus.inst_retire   = v.retire;
    bus.uart_rx_valid = v.rxv;
    bus.uart_rx_data  = v.rxd;
    bus.uart_tx_ready = v.txr;
    #1;
    rx_empty = (m_rxq.size() == 0);
    tx_empty = (m_txq.size() == 0);
    check("rx_ready", {31'b0, bus.uart_rx_ready}, {31'b0, rx_empty && !v.rst});
    check("tx_valid", {31'b0, bus.uart_tx_valid}, {31'b0, !tx_empty});
    if (!tx_empty) check("tx_data", {24'b0, bus.uart_tx_data}, {24'b0, m_txq[0]});

    if (v.rst) begin
      exp_rd = 0;
      m_rxq.delete();
      m_txq.delete();
      m_rx_last = 0;
      m_cycle = 0;
      m_instr = 0;
    end else begin
      exp_rd = v.re ? mread(v.addr) : m_rdata;
      if (v.re && v.addr == A_RX && !rx_empty) void'(m_rxq.pop_front());
      if (v.rxv && rx_empty) begin
        m_rxq.push_back(v.rxd);
        m_rx_last = v.rxd;
      end
      hs = !tx_empty && v.txr;
      if (hs) void'(m_txq.pop_front());
      if (v.we && v.addr == A_TX && (tx_empty || hs)) m_txq.push_back(v.wdata[7:0]);
      if (v.we && v.addr == A_RST) begin
        m_cycle = 0;
        m_instr = 0;
      end else begin
        m_cycle = m_cycle + 1;
        m_instr = m_instr + {31'b0, v.retire};
      end
    end
    m_rdata = exp_rd;

    @(posedge clk);
    #1;
    check("rdata_model", bus.rdata, m_rdata);
    if (v.chk) check("rdata_vec", bus.rdata, v.exp);
    @(negedge clk);
  endtask

  function automatic vec_t idle();
    vec_t v = '{rst:0, addr:32'h0, wdata:32'h0, we:0, re:0, retire:0,
                rxv:0, rxd:8'h0, txr:0, chk:0, exp:32'h0};
    return v;
  endfunction

  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] e);
    vec_t v = idle();
    v.addr = a; v.re = 1; v.chk = 1; v.exp = e;
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [31:0] d, input logic txr);
    vec_t v = idle();
    v.addr = a; v.wdata = d; v.we = 1; v.txr = txr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.addr = 0; bus.wdata = 0; bus.we = 0; bus.re = 0; bus.inst_retire = 0;
    bus.uart_rx_valid = 0; bus.uart_rx_data = 0; bus.uart_tx_ready = 0;
    @(negedge clk);

    v = idle(); v.rst = 1; v.chk = 1; tbl.push_back(v);
    v = idle(); v.rst = 1; tbl.push_back(v);
    tbl.push_back(rd(A_CTRL, 32'h1));
    v = idle(); v.rxv = 1; v.rxd = 8'hA5; tbl.push_back(v);
    tbl.push_back(rd(A_CTRL, 32'h3));
    tbl.push_back(rd(A_RX,   32'hA5));
    tbl.push_back(rd(A_CTRL, 32'h1));
    tbl.push_back(rd(A_RX,   32'hA5));
    tbl.push_back(rd(A_CTRL, 32'h1));
    tbl.push_back(wr(A_TX, 32'h1234_5641, 0));
    tbl.push_back(rd(A_CTRL, 32'h0));
    tbl.push_back(wr(A_TX, 32'h0000_0042, 0));
    v = idle(); v.txr = 1; tbl.push_back(v);
    tbl.push_back(rd(A_CTRL, 32'h1));
    tbl.push_back(wr(A_TX, 32'h0000_0055, 0));
    tbl.push_back(wr(A_TX, 32'h0000_0043, 1));
    tbl.push_back(rd(A_CTRL, 32'h0));
    v = idle(); v.txr = 1; tbl.push_back(v);
    tbl.push_back(rd(A_N0C, 32'h0));
    tbl.push_back(rd(A_N20, 32'h0));
    tbl.push_back(wr(A_RX, 32'hFFFF_FFFF, 0));
    tbl.push_back(rd(A_CTRL, 32'h1));
    tbl.push_back(wr(A_RST, 32'h0, 0));
    tbl.push_back(rd(A_INS, 32'h0));
    tbl.push_back(rd(A_CYC, 32'h1));
    for (int i = 0; i < 10; i++) begin
      v = idle(); v.retire = (i % 2 == 0); tbl.push_back(v);
    end
    tbl.push_back(rd(A_INS, 32'h5));
    tbl.push_back(rd(A_CYC, 32'd13));
    v = idle(); v.rxv = 1; v.rxd = 8'h77; tbl.push_back(v);
    tbl.push_back(wr(A_TX, 32'h99, 0));
    tbl.push_back(rd(A_CTRL, 32'h2));
    v = idle(); v.rst = 1; v.re = 1; v.addr = A_CTRL; v.chk = 1; tbl.push_back(v);
    tbl.push_back(rd(A_CTRL, 32'h1));

    foreach (tbl[i]) step(tbl[i]);

    // Counter wrap: preload the cycle counter just below the top.
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cycle = 32'hFFFF_FFFE;
    step(rd(A_CYC, 32'hFFFF_FFFE));
    step(rd(A_CYC, 32'hFFFF_FFFF));
    step(rd(A_CYC, 32'h0));
    step(rd(A_CYC, 32'h1));

    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      v = idle();
      sel = $urandom_range(0, 15);
      case (sel)
        0, 1, 2: v.addr = A_CTRL;
        3, 4:    v.addr = A_RX;
        5, 6, 7: v.addr = A_TX;
        8, 9:    v.addr = A_CYC;
        10, 11:  v.addr = A_INS;
        12:      v.addr = ($urandom_range(0, 7) == 0) ? A_RST : A_N0C;
        13:      v.addr = A_N20;
        default: v.addr = $urandom();
      endcase
      v.wdata  = $urandom();
      v.we     = $urandom_range(0, 1);
      v.re     = $urandom_range(0, 1);
      v.retire = $urandom_range(0, 1);
      v.rxv    = $urandom_range(0, 1);
      v.rxd    = 8'($urandom());
      v.txr    = ($urandom_range(0, 2) == 0);
      v.rst    = ($urandom_range(0, 99) == 0);
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
